// File: rtl/alu_seq_unit.sv
// ALU with single-cycle ops and a multi-cycle shift-add unsigned multiply.
// Completed ops publish result/zero/illegal with a one-cycle done pulse.
module alu_seq_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       ALU_Op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SLT  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_MFHI = 3'd6;
  localparam logic [2:0] OP_MFLO = 3'd7;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [2:0]       op;
  logic             bad;
  logic             mul_hit;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic             last;

  assign busy    = (state == S_MUL);
  assign mul_hit = MUL_EN && (func == 6'b011001);

  // Decode: full 6-bit funcs win over the low-nibble matches
  always_comb begin
    op  = OP_ADD;
    bad = 1'b0;
    if (!ALU_Op[1]) begin
      op = ALU_Op[0] ? OP_SUB : OP_ADD;
    end else if (mul_hit) begin
      op = OP_MUL;
    end else if (func == 6'b010000) begin
      op = OP_MFHI;
    end else if (func == 6'b010010) begin
      op = OP_MFLO;
    end else begin
      unique case (func[3:0])
        4'b0000: op = OP_ADD;
        4'b0010: op = OP_SUB;
        4'b0100: op = OP_AND;
        4'b0101: op = OP_OR;
        4'b1010: op = OP_SLT;
        default: begin
          bad = 1'b1;
          op  = ALU_Op[0] ? OP_SUB : OP_AND;
        end
      endcase
    end
  end

  // Single-cycle datapath
  always_comb begin
    alu_y = '0;
    unique case (op)
      OP_ADD:  alu_y = a + b;
      OP_SUB:  alu_y = a - b;
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}},
                        ($signed(a) < $signed(b))};
      OP_MFHI: alu_y = hi;
      OP_MFLO: alu_y = lo;
      default: alu_y = '0;
    endcase
  end

  // One shift-add step: add multiplicand on LSB, shift pair right
  always_comb begin
    sum    = {1'b0, acc_hi}
           + (acc_lo[0] ? {1'b0, mcand} : '0);
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    last   = (cnt == CW'(1));
  end

  // FSM, multiply iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      result  <= '0;
      zero    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          if (op == OP_MUL) begin
            state  <= S_MUL;
            cnt    <= CW'(WIDTH);
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
          end else begin
            result  <= alu_y;
            zero    <= (alu_y == '0);
            illegal <= bad;
            done    <= 1'b1;
          end
        end
      end else if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt    <= cnt - CW'(1);
        if (last) begin
          state   <= S_IDLE;
          hi      <= nxt_hi;
          lo      <= nxt_lo;
          result  <= nxt_lo;
          zero    <= (nxt_lo == '0);
          illegal <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: 32-bit with multiply,
// plus an 8-bit instance with the multiplier disabled.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  ALU_Op;
  logic [5:0]  func;
  logic [31:0] a;
  logic [31:0] b;

  logic [31:0] result;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        illegal;

  logic [7:0]  result8;
  logic        zero8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;
  logic        busy8;
  logic        done8;
  logic        illegal8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .ALU_Op(ALU_Op), .func(func), .a(a), .b(b),
    .result(result), .zero(zero), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .illegal(illegal)
  );

  alu_seq_unit #(.WIDTH(8), .MUL_EN(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .ALU_Op(ALU_Op), .func(func), .a(a[7:0]), .b(b[7:0]),
    .result(result8), .zero(zero8), .hi(hi8), .lo(lo8),
    .busy(busy8), .done(done8), .illegal(illegal8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one accepted edge; returns on the next negedge
  task automatic op(input logic [1:0] o, input logic [5:0] f,
                    input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    ALU_Op = o;
    func   = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for done; report cycles and busy cycles seen
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int bcnt;
  int seen_done;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    ALU_Op = 2'b00;
    func   = 6'b000000;
    a      = '0;
    b      = '0;
    #12;
    chk("rst_result", 64'(result), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_hilo", 64'({hi, lo}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // slt signed: -1 < 1
    op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    chk("slt_res", 64'(result), 64'd1);
    chk("slt_zero", 64'(zero), 64'd0);
    chk("slt_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("slt_done_drop", 64'(done), 64'd0);

    // back-to-back sub then add-wrap
    @(negedge clk);
    ALU_Op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    chk("sub_res", 64'(result), 64'd0);
    chk("sub_zero", 64'(zero), 64'd1);
    chk("sub_done", 64'(done), 64'd1);
    ALU_Op = 2'b00; a = 32'hFFFF_FFFF; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("add_wrap", 64'(result), 64'd0);
    chk("b2b_done", 64'(done), 64'd1);

    // R-type and/or/add/sub
    op(2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00);
    chk("r_and", 64'(result), 64'h0000_F000);
    op(2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00);
    chk("r_or", 64'(result), 64'h0000_FFF0);
    op(2'b10, 6'b100000, 32'd3, 32'd4);
    chk("r_add", 64'(result), 64'd7);
    op(2'b10, 6'b100010, 32'd3, 32'd4);
    chk("r_sub", 64'(result), 64'hFFFF_FFFF);
    op(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF);
    chk("slt_false", 64'(result), 64'd0);

    // multu max * max
    op(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_busy", 64'(busy), 64'd1);
    wait_done(cyc, bcnt);
    chk("mul_lat", 64'(cyc), 64'd33);
    chk("mul_bcnt", 64'(bcnt), 64'd32);
    chk("mul_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("mul_lo", 64'(lo), 64'h0000_0001);
    chk("mul_res", 64'(result), 64'h1);
    chk("mul_idle", 64'(busy), 64'd0);
    op(2'b10, 6'b010000, 32'd0, 32'd0);
    chk("mfhi", 64'(result), 64'hFFFF_FFFE);
    chk("mfhi_hi", 64'(hi), 64'hFFFF_FFFE);

    // multu 7*6 with ignored start and operand churn
    op(2'b10, 6'b011001, 32'd7, 32'd6);
    repeat (2) @(negedge clk);
    ALU_Op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'hFF; b = 32'hFF;
    chk("ign_done", 64'(done), 64'd0);
    wait_done(cyc, bcnt);
    chk("mul2_lat", 64'(cyc), 64'd30);
    chk("mul2_lo", 64'(lo), 64'd42);
    chk("mul2_hi", 64'(hi), 64'd0);
    chk("mul2_res", 64'(result), 64'd42);

    // flush at cycle 10 of a second multu
    op(2'b10, 6'b011001, 32'd3, 32'd3);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy", 64'(busy), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    chk("fl_nodone", 64'(seen_done), 64'd0);
    chk("fl_hilo", 64'({hi, lo}), {32'd0, 32'd42});
    chk("fl_res", 64'(result), 64'd42);
    op(2'b10, 6'b010010, 32'd0, 32'd0);
    chk("mflo", 64'(result), 64'd42);

    // undecodable func, ALU_Op=11 -> sub
    op(2'b11, 6'b111111, 32'd10, 32'd3);
    chk("ill_res", 64'(result), 64'd7);
    chk("ill_flag", 64'(illegal), 64'd1);
    op(2'b10, 6'b100000, 32'd1, 32'd1);
    chk("ill_clear", 64'(illegal), 64'd0);

    // WIDTH=8 MUL_EN=0: multu func decodes illegal -> and
    op(2'b10, 6'b011001, 32'h3C, 32'h0F);
    chk("w8_res", 64'(result8), 64'h0C);
    chk("w8_ill", 64'(illegal8), 64'd1);
    chk("w8_busy", 64'(busy8), 64'd0);
    @(negedge clk);
    chk("w8_busy2", 64'(busy8), 64'd0);

    // async reset in the middle of a multiply
    op(2'b10, 6'b011001, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_res", 64'(result), 64'd0);
    chk("ar_hilo", 64'({hi, lo}), 64'd0);
    chk("ar_flags", 64'({busy, done, illegal, zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(2'b00, 6'b000000, 32'd2, 32'd3);
    chk("ar_post", 64'(result), 64'd5);
    chk("ar_pdone", 64'(done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal range 4..64.
REQ-002 Parameter MUL_EN, default 1, enables the multi-cycle unsigned multiply; 0 decodes multu as illegal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 flush  input  1  synchronous abort of an in-flight multiply.
REQ-007 ALU_Op  input  2  main-decoder op class (00 add, 01 sub, 1x R-type by func).
REQ-008 func  input  6  R-type function field.
REQ-009 a, b  input  WIDTH  operands, captured on accepted start.
REQ-010 result  output  WIDTH  registered result of the last completed op.
REQ-011 zero  output  1  registered, result==0 for the last completed op.
REQ-012 hi, lo  output  WIDTH  registered product halves of the last completed multu.
REQ-013 busy  output  1  high while a multiply is in flight.
REQ-014 done  output  1  single-cycle completion pulse.
REQ-015 illegal  output  1  registered; high with done when the accepted func was undecodable.

Function
REQ-016 Decode at accept: ALU_Op=00 add; 01 sub; 1x with func[3:0] 0000 add, 0010 sub, 0100 and, 0101 or, 1010 slt; func=011001 multu (MUL_EN=1); func=010000 mfhi; func=010010 mflo.
REQ-017 Undecodable R-type func: ALU_Op=10 executes and, ALU_Op=11 executes sub; illegal=1 with the done pulse.
REQ-018 Precedence: full 6-bit matches (multu, mfhi, mflo) before func[3:0] matches.
REQ-019 add/sub wrap modulo 2^WIDTH; no overflow output.
REQ-020 slt: signed two's-complement a<b gives result 1 (zero-extended), else 0.
REQ-021 mfhi/mflo: result = current hi/lo; hi/lo unchanged.
REQ-022 FSM states IDLE, MUL. IDLE+start+single op: stay IDLE, result/zero/illegal updated and done=1 on that same edge (latency 1).
REQ-023 IDLE+start+multu: go MUL, busy=1 from that edge, load counter=WIDTH, multiplicand=a, multiplier=b, partial=0.
REQ-024 MUL: one shift-add iteration per cycle, counter decrements; after exactly WIDTH iterations return IDLE, busy=0, done=1, {hi,lo}=a*b (2*WIDTH bits unsigned), result=lo, zero=(lo==0). Total latency WIDTH+1 edges from accept.
REQ-025 start while busy=1 ignored; no queuing.
REQ-026 flush in MUL: return IDLE next edge, busy=0, no done, hi/lo/result unchanged; flush in IDLE no effect; flush has priority over completion on the same edge.
REQ-027 done deasserts the edge after assertion; back-to-back single ops yield done high on consecutive cycles.
REQ-028 Operands not sampled while busy; a/b changes mid-multiply do not affect product.

Reset
REQ-029 rst_n=0 forces IDLE, result=0, zero=0, hi=0, lo=0, busy=0, done=0, illegal=0, counter=0 immediately, independent of clk.
REQ-030 Reset during MUL aborts the multiply; first start after release is accepted normally.

Verification
REQ-031 WIDTH=32: ALU_Op=10 func=101010 a=0xFFFFFFFF b=1 start -> next edge result=1, zero=0, done=1 one cycle.
REQ-032 ALU_Op=01 a=5 b=5 -> result=0, zero=1, done=1; ALU_Op=00 a=0xFFFFFFFF b=1 -> result=0 (wrap).
REQ-033 multu a=0xFFFFFFFF b=0xFFFFFFFF -> busy 32 cycles, done on edge 33, hi=0xFFFFFFFE, lo=0x00000001; mfhi then returns 0xFFFFFFFE.
REQ-034 multu a=7 b=6, start re-pulsed with ALU_Op=00 mid-operation -> ignored, lo=42, hi=0; then flush at cycle 10 of a second multu -> no done, hi/lo stay 0/42.
REQ-035 ALU_Op=11 func=111111 -> sub result, illegal=1; rst_n low mid-multiply -> all outputs 0 asynchronously.
REQ-036 WIDTH=8 MUL_EN=0: func=011001 ALU_Op=10 -> and result, illegal=1, busy never asserts.
